clk_div_prog: RTL and testbench

// - Runtime-programmable integer clock divider: o_clk = clk/N, N in [2, 2^CNT_W-1], 50% duty for odd and even N.
// - Generalises the fixed divide-by-3 block; adds enable gating, glitch-free divisor switching and a period tick.
// - Sits between the system clock and slow peripheral or strobe logic that needs a derived clock or enable.

---
 rtl/clk_div_pkg.sv | 11 +
 rtl/clk_div_neg_stage.sv | 21 ++
 rtl/clk_div_prog.sv | 108 ++++++++++
 tb/tb_clk_div_prog.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared state type and limits for the runtime-programmable clock divider.
package clk_div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_neg_stage.sv
// Negative-edge half of the divider: half-cycle delayed copy of p that
// stretches the high phase of odd divisors to exactly N/2 clk periods.
module clk_div_neg_stage (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_p,
  input  logic i_odd,
  output logic o_clk
);

  logic r_n;

  always_ff @(negedge i_clk) begin
    if (i_rst) r_n <= 1'b0;
    else       r_n <= i_p;
  end

  // p and n never toggle on the same edge, so the OR is glitch-free.
  assign o_clk = i_odd ? (i_p | r_n) : i_p;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50%-duty integer clock divider with enable gating,
// boundary-aligned divisor switching and a per-period tick.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_div_load,
  input  logic [CNT_W-1:0] i_div_in,
  output logic             o_div_busy,
  output logic             o_div_err,
  output logic [CNT_W-1:0] o_div_active,
  output logic             o_clk,
  output logic             o_tick
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_pending;
  logic [CNT_W-1:0] r_active;
  logic             r_p;
  logic             r_tick;
  logic             r_busy;
  logic             r_err;

  logic [CNT_W-1:0] w_half;
  logic [CNT_W-1:0] w_nextCnt;
  logic             w_wrap;
  logic             w_boundary;
  logic             w_loadOk;
  logic             w_loadBad;

  assign w_half     = r_active >> 1;
  assign w_wrap     = (r_cnt == r_active - 1'b1);
  assign w_nextCnt  = w_wrap ? '0 : r_cnt + 1'b1;
  assign w_boundary = (r_state == IDLE) || w_wrap;
  assign w_loadOk   = i_div_load && (i_div_in >= CNT_W'(MIN_DIV));
  assign w_loadBad  = i_div_load && (i_div_in <  CNT_W'(MIN_DIV));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_p       <= 1'b0;
      r_tick    <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_active  <= CNT_W'(DEFAULT_DIV);
      r_pending <= '0;
    end else begin
      r_err <= w_loadBad;
      // A boundary consumes the old pending value before a same-cycle load refills it.
      if (w_boundary && r_busy) begin
        r_active <= r_pending;
        r_busy   <= 1'b0;
      end
      if (w_loadOk) begin
        r_pending <= i_div_in;
        r_busy    <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (i_en) begin
            r_state <= RUN;
            r_p     <= 1'b1;
            r_tick  <= 1'b1;
          end else begin
            r_p    <= 1'b0;
            r_tick <= 1'b0;
          end
        end
        RUN: begin
          // en only matters at the wrap, so a started period always completes.
          if (w_wrap && !i_en) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_p     <= 1'b0;
            r_tick  <= 1'b0;
          end else begin
            r_cnt  <= w_nextCnt;
            r_p    <= (w_nextCnt < w_half);
            r_tick <= (w_nextCnt == '0);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  clk_div_neg_stage u_negStage (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_p   (r_p),
    .i_odd (r_active[0]),
    .o_clk (o_clk)
  );

  assign o_tick       = r_tick;
  assign o_div_busy   = r_busy;
  assign o_div_err    = r_err;
  assign o_div_active = r_active;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: a period-level model predicts every
// output each half-cycle, and measured high/low times are held against it.
module tb_clk_div_prog;

  localparam int CNT_W       = 8;
  localparam int DEFAULT_DIV = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             divLoad;
  logic [CNT_W-1:0] divIn;
  logic             divBusy;
  logic             divErr;
  logic [CNT_W-1:0] divActive;
  logic             oClk;
  logic             oTick;

  int compared   = 0;
  int mismatched = 0;

  // Model state: whether a period is running, position inside it, divisors.
  bit mValid     = 0;
  bit mRunning   = 0;
  int mPos       = 0;
  int mActive    = DEFAULT_DIV;
  int mPending   = 0;
  bit mBusy      = 0;
  bit mErr       = 0;
  bit mTick      = 0;
  bit mJustReset = 0;
  int disturbCount = 0;

  // Edge measurement state.
  bit prevClk    = 0;
  int runLen     = 0;
  bit haveRise   = 0;
  bit haveFall   = 0;
  int snap       = 0;
  int prevN      = 0;
  int lastHighNs = 0;
  int lastLowNs  = 0;
  int rises      = 0;
  int dutTicks   = 0;
  int errPulses  = 0;
  bit saw50      = 0;

  always #10 clk = ~clk;

  clk_div_prog #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_en         (en),
    .i_div_load   (divLoad),
    .i_div_in     (divIn),
    .o_div_busy   (divBusy),
    .o_div_err    (divErr),
    .o_div_active (divActive),
    .o_clk        (oClk),
    .o_tick       (oTick)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic ld, input logic [CNT_W-1:0] d);
    rst     = r;
    en      = e;
    divLoad = ld;
    divIn   = d;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic waitPeriodPos(input int pos, input int n);
    int guard = 0;
    while (!(mRunning && mPos == pos && mActive == n) && guard < 200) begin
      stepCycles(1);
      guard++;
    end
    checkOutput("wait_pos_reached", (guard < 200) ? 1 : 0, 1);
  endtask

  // o_clk must be high for the first N half-cycles of each N-cycle period.
  function automatic int expHigh(input int half);
    return (mRunning && (2 * mPos + half < mActive)) ? 1 : 0;
  endfunction

  task automatic trackEdges(input logic s);
    if (s && !prevClk) begin
      if (haveFall && snap == disturbCount) begin
        checkOutput("low_ns", runLen * 10, prevN * 10);
        lastLowNs = runLen * 10;
      end
      haveRise = 1;
      snap     = disturbCount;
      rises++;
      runLen   = 1;
    end else if (!s && prevClk) begin
      if (haveRise && snap == disturbCount) begin
        checkOutput("high_ns", runLen * 10, mActive * 10);
        lastHighNs = runLen * 10;
        if (runLen == 5) saw50 = 1;
        haveFall = 1;
        prevN    = mActive;
      end else begin
        haveFall = 0;
      end
      snap   = disturbCount;
      runLen = 1;
    end else begin
      runLen++;
    end
    prevClk = s;
  endtask

  // Period-level model: a period of N cycles, divisor swaps only between periods.
  always @(posedge clk) begin
    if (rst) begin
      mValid     = 1;
      mRunning   = 0;
      mPos       = 0;
      mActive    = DEFAULT_DIV;
      mPending   = 0;
      mBusy      = 0;
      mErr       = 0;
      mTick      = 0;
      mJustReset = 1;
      disturbCount++;
    end else begin
      mJustReset = 0;
      mErr       = divLoad && (divIn < 2);
      mTick      = 0;
      if (mRunning && mPos < mActive - 1) begin
        mPos++;
      end else begin
        if (mBusy) begin
          mActive = mPending;
          mBusy   = 0;
        end
        if (en) begin
          mRunning = 1;
          mPos     = 0;
          mTick    = 1;
        end else if (mRunning) begin
          mRunning = 0;
          mPos     = 0;
          disturbCount++;
        end
      end
      if (divLoad && divIn >= 2) begin
        mPending = divIn;
        mBusy    = 1;
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (mValid) begin
      checkOutput("tick", oTick, mTick);
      checkOutput("busy", divBusy, mBusy);
      checkOutput("err", divErr, mErr);
      checkOutput("active", divActive, mActive);
      if (!mJustReset) checkOutput("clk_first_half", oClk, expHigh(0));
      if (oTick === 1'b1) dutTicks++;
      if (divErr === 1'b1) errPulses++;
      trackEdges(oClk === 1'b1);
    end
    @(negedge clk);
    #1;
    if (mValid) begin
      checkOutput("clk_second_half", oClk, expHigh(1));
      trackEdges(oClk === 1'b1);
    end
  end

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    stepCycles(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    checkOutput("reset_active", divActive, 3);
    checkOutput("reset_busy", divBusy, 0);
    checkOutput("reset_clk", oClk, 0);

    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    stepCycles(13);
    checkOutput("n3_high_ns", lastHighNs, 30);
    checkOutput("n3_low_ns", lastLowNs, 30);

    waitPeriodPos(1, 3);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd4);
    stepCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    checkOutput("busy_after_load", divBusy, 1);
    checkOutput("active_before_wrap", divActive, 3);
    stepCycles(17);
    checkOutput("n4_high_ns", lastHighNs, 40);
    checkOutput("n4_low_ns", lastLowNs, 40);

    waitPeriodPos(0, 4);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd5);
    stepCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    stepCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd7);
    stepCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    stepCycles(30);
    checkOutput("n7_high_ns", lastHighNs, 70);
    checkOutput("n7_low_ns", lastLowNs, 70);
    checkOutput("n5_never_seen", saw50, 0);

    applyStimulus(1'b0, 1'b1, 1'b1, 8'd1);
    stepCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd0);
    stepCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    stepCycles(2);
    checkOutput("err_pulse_count", errPulses, 2);
    checkOutput("active_after_err", divActive, 7);

    applyStimulus(1'b0, 1'b1, 1'b1, 8'd6);
    stepCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    waitPeriodPos(1, 6);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
    stepCycles(12);
    checkOutput("idle_clk", oClk, 0);
    checkOutput("idle_tick", oTick, 0);
    checkOutput("n6_high_ns", lastHighNs, 60);

    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    @(posedge clk);
    #1;
    checkOutput("en_rise_same_edge", oClk, 1);
    checkOutput("en_rise_tick", oTick, 1);
    #1;

    applyStimulus(1'b0, 1'b1, 1'b1, 8'd5);
    stepCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    waitPeriodPos(0, 5);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd9);
    stepCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0);
    stepCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
    @(negedge clk);
    #1;
    checkOutput("rst_clk_low_by_negedge", oClk, 0);
    checkOutput("rst_active", divActive, 3);
    checkOutput("rst_busy", divBusy, 0);
    stepCycles(20);
    checkOutput("rst_pending_dropped", divActive, 3);
    checkOutput("post_rst_high_ns", lastHighNs, 30);

    checkOutput("tick_vs_rise", dutTicks, rises);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
